mem_access_unit: RTL

- Memory stage for the pipeline: one load or store per instruction over the dCache core bus (reqcyc/reqack/respcyc/respack).
- Parametrised in address, data, opcode and tag widths.
- Handles loads (address beat, then a response), and posted stores (address beat, then a data beat, with no response).
- Provides writeback back-pressure via a result hold state, a pipeline flush that discards in-flight results, and an optional response timeout.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/mem_timeout_counter.sv | 30 +++
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Bus encodings, FSM states and the tag builder shared by the memory-access stage.
// Tag layout is {rw, target, opcode}, with the opcode in the low bits.
package mem_bus_pkg;

  localparam logic       RW_READ    = 1'b1;
  localparam logic       RW_WRITE   = 1'b0;
  localparam logic [3:0] TGT_MEMORY = 4'h1;

  localparam int OP_MAX_W  = 32;
  localparam int TAG_MAX_W = 1 + 4 + OP_MAX_W;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT, DONE, HOLD} state_e;

  // The opcode is passed zero-extended; op_w places the header directly above it.
  function automatic logic [TAG_MAX_W-1:0] build_tag(input logic                rw,
                                                     input logic [3:0]          tgt,
                                                     input logic [OP_MAX_W-1:0] op,
                                                     input int                  op_w);
    logic [TAG_MAX_W-1:0] hdr;
    hdr = TAG_MAX_W'({rw, tgt});
    return (hdr << op_w) | TAG_MAX_W'(op);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Response-wait counter: counts enabled cycles and flags the LIMIT-th one; LIMIT=0 never expires.
// Clear has priority over enable.
module mem_timeout_counter #(
  parameter int LIMIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam int LAST  = (LIMIT > 0) ? LIMIT - 1 : 0;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = (LIMIT != 0) && i_en && (r_count == CNT_W'(LAST));

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: one load (address beat + response) or posted store (address + data beat) per instruction.
// Result follows the last bus handshake by one DONE cycle; stall_out holds upstream while busy, wb_stall_in holds the result.
module mem_access_unit
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int OP_W           = 8,
  parameter int TAG_W          = 13,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic              in_flush,
  input  logic              wb_stall_in,
  output logic              stall_out,
  output logic              done_valid,
  output logic              mem_success,
  output logic [DATA_W-1:0] load_data,
  output logic              error_timeout,
  output logic              req_cyc,
  output logic [DATA_W-1:0] req,
  output logic [TAG_W-1:0]  req_tag,
  input  logic              req_ack,
  input  logic              resp_cyc,
  input  logic [DATA_W-1:0] resp,
  output logic              resp_ack
);

  state_e            r_state;
  logic              r_is_load;
  logic              r_discard;
  logic              r_ok;
  logic [DATA_W-1:0] r_store_data;
  logic              r_req_cyc;
  logic [DATA_W-1:0] r_req;
  logic [TAG_W-1:0]  r_req_tag;
  logic              r_resp_ack;
  logic              r_done_vld;
  logic              r_success;
  logic              r_err;
  logic [DATA_W-1:0] r_load_data;

  logic              w_is_mem;
  logic              w_accept;
  logic              w_expired;
  logic [TAG_W-1:0]  w_tag;

  assign w_is_mem = in_is_load | in_is_store;
  assign w_accept = (r_state == IDLE) && in_valid && !in_flush;
  assign w_tag    = TAG_W'(build_tag(in_is_load ? RW_READ : RW_WRITE, TGT_MEMORY,
                                     OP_MAX_W'(in_opcode), OP_W));

  assign stall_out = (r_state != IDLE) || (in_valid && w_is_mem && (r_state == IDLE));

  mem_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (reset),
    .i_en     (r_state == WAIT),
    .i_clr    (r_state != WAIT),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_is_load    <= 1'b0;
      r_discard    <= 1'b0;
      r_ok         <= 1'b0;
      r_store_data <= '0;
      r_req_cyc    <= 1'b0;
      r_req        <= '0;
      r_req_tag    <= '0;
      r_resp_ack   <= 1'b0;
      r_done_vld   <= 1'b0;
      r_success    <= 1'b0;
      r_err        <= 1'b0;
      r_load_data  <= '0;
    end else begin
      r_done_vld <= 1'b0;
      r_success  <= 1'b0;
      r_resp_ack <= 1'b0;
      // A flush only marks the instruction; the bus beats already committed still finish.
      if ((r_state != IDLE) && in_flush) begin
        r_discard <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_discard    <= 1'b0;
            r_ok         <= 1'b1;
            r_load_data  <= '0;
            r_is_load    <= in_is_load;
            r_store_data <= in_store_data;
            if (w_is_mem) begin
              r_req_cyc <= 1'b1;
              r_req     <= DATA_W'(in_addr);
              r_req_tag <= w_tag;
              r_state   <= ADDR;
            end else if (!wb_stall_in) begin
              r_done_vld <= 1'b1;
              r_success  <= 1'b1;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        ADDR: begin
          if (req_ack) begin
            if (r_is_load) begin
              r_req_cyc <= 1'b0;
              r_state   <= WAIT;
            end else begin
              r_req   <= r_store_data;
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (req_ack) begin
            r_req_cyc <= 1'b0;
            r_state   <= DONE;
          end
        end
        WAIT: begin
          if (resp_cyc) begin
            r_load_data <= resp;
            r_resp_ack  <= 1'b1;
            r_state     <= DONE;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_ok    <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE, HOLD: begin
          if (r_discard || in_flush) begin
            r_state <= IDLE;
          end else if (!wb_stall_in) begin
            r_done_vld <= 1'b1;
            r_success  <= r_ok;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done_valid    = r_done_vld;
  assign mem_success   = r_success;
  assign load_data     = r_load_data;
  assign error_timeout = r_err;
  assign req_cyc       = r_req_cyc;
  assign req           = r_req;
  assign req_tag       = r_req_tag;
  assign resp_ack      = r_resp_ack;

endmodule
